// File: rtl/factor_search_12.sv
// Sequential factor search: walks (x, y) pairs with 2 <= x <= y <= 63 in ascending
// order and reports the first pair whose product equals the captured target.
module factor_search_12 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] a,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [5:0]  f1,
  output logic [5:0]  f2
);

  typedef enum logic {IDLE, SEARCH} state_t;

  state_t      state_q, state_d;
  logic [5:0]  x_q, x_d;
  logic [5:0]  y_q, y_d;
  logic [11:0] tgt_q, tgt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        found_q, found_d;
  logic [5:0]  f1_q, f1_d;
  logic [5:0]  f2_q, f2_d;

  logic [11:0] prod;
  logic [11:0] sq;
  logic        x_max;

  // 63*63 = 3969 fits in 12 bits, so neither product can wrap
  assign prod  = {6'd0, x_q} * {6'd0, y_q};
  assign sq    = {6'd0, x_q} * {6'd0, x_q};
  assign x_max = (x_q == 6'd63);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    tgt_d   = tgt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    found_d = found_q;
    f1_d    = f1_q;
    f2_d    = f2_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_d   = a;
          x_d     = 6'd2;
          y_d     = 6'd2;
          busy_d  = 1'b1;
          found_d = 1'b0;
          f1_d    = 6'd0;
          f2_d    = 6'd0;
          state_d = SEARCH;
        end
      end

      SEARCH: begin
        if (prod == tgt_q) begin
          found_d = 1'b1;
          f1_d    = x_q;
          f2_d    = y_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if ((sq > tgt_q) || (x_max && ((y_q == 6'd63) || (prod > tgt_q)))) begin
          found_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if ((prod > tgt_q) || (y_q == 6'd63)) begin
          // Restart the row at y = x so that f1 <= f2 is always preserved
          x_d = x_q + 6'd1;
          y_d = x_q + 6'd1;
        end else begin
          y_d = y_q + 6'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= 6'd0;
      y_q     <= 6'd0;
      tgt_q   <= 12'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      f1_q    <= 6'd0;
      f2_q    <= 6'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      tgt_q   <= tgt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign f1    = f1_q;
  assign f2    = f2_q;

endmodule

// File: tb/tb_factor_search_12.sv
// Directed bench for factor_search_12: an arithmetic reference model pushes expected
// results and latencies into a queue at start; they are popped and compared at done.
module tb_factor_search_12;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] a;
  logic        busy;
  logic        done;
  logic        found;
  logic [5:0]  f1;
  logic [5:0]  f2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int fnd;
    int e1;
    int e2;
    int evals;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;

  factor_search_12 dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .found (found),
    .f1    (f1),
    .f2    (f2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Closed-form count of evaluations: each row x costs the y values from x up to the
  // first product above the target (or 63), and the row whose x*x exceeds it costs one.
  function automatic exp_t model(input int tv);
    exp_t r;
    int ymax;
    r.fnd = 0; r.e1 = 0; r.e2 = 0; r.evals = 0;
    for (int x = 2; x <= 63; x++) begin
      if (x * x > tv) begin
        r.evals += 1;
        return r;
      end
      if ((tv % x == 0) && (tv / x <= 63)) begin
        r.evals += tv / x - x + 1;
        r.fnd = 1; r.e1 = x; r.e2 = tv / x;
        return r;
      end
      ymax = (tv / x + 1 < 63) ? tv / x + 1 : 63;
      r.evals += ymax - x + 1;
    end
    return r;
  endfunction

  // Called #1 after an edge; start is sampled on the following edge (edge 0)
  task automatic run_search(input logic [11:0] val, input int inject_at, input string tag);
    exp_t e;
    int cyc;
    exp_q.push_back(model(int'(val)));
    a = val;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_after_start"}, int'(busy), 1);
    cyc = 1;
    while (!done && cyc < 5000) begin
      if (cyc == inject_at) begin
        start = 1'b1;
        a = 12'd15;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    e = exp_q.pop_front();
    last_exp = e;
    check({tag, ".done_seen"}, int'(done), 1);
    check({tag, ".latency"}, cyc, e.evals + 1);
    check({tag, ".busy_at_done"}, int'(busy), 0);
    check({tag, ".found"}, int'(found), e.fnd);
    check({tag, ".f1"}, int'(f1), e.e1);
    check({tag, ".f2"}, int'(f2), e.e2);
  endtask

  task automatic check_hold(input string tag);
    @(posedge clk); #1;
    check({tag, ".done_pulse_end"}, int'(done), 0);
    check({tag, ".found_hold"}, int'(found), last_exp.fnd);
    check({tag, ".f1_hold"}, int'(f1), last_exp.e1);
    check({tag, ".f2_hold"}, int'(f2), last_exp.e2);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = 12'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check("reset.found", int'(found), 0);
    check("reset.f1", int'(f1), 0);
    check("reset.f2", int'(f2), 0);
    rst = 1'b0;

    run_search(12'd15, -1, "a15");
    check_hold("a15");
    run_search(12'd13, -1, "a13");
    check_hold("a13");
    run_search(12'd4, -1, "a4");
    run_search(12'd0, -1, "a0");
    // start raised in the done cycle of the previous search
    run_search(12'd1, -1, "a1_backtoback");
    run_search(12'd2, -1, "a2");
    run_search(12'd3, -1, "a3");
    run_search(12'd97, -1, "a97");
    run_search(12'd3843, -1, "a3843");
    run_search(12'd4095, 500, "a4095");
    check_hold("a4095");

    // Abort a long search with reset; no done pulse may follow
    a = 12'd3969;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (99) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort.busy", int'(busy), 0);
    check("abort.done", int'(done), 0);
    check("abort.found", int'(found), 0);
    check("abort.f1", int'(f1), 0);
    check("abort.f2", int'(f2), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_search(12'd15, -1, "a15_after_reset");

    for (int i = 0; i < 6; i++) begin
      run_search(12'($urandom_range(0, 4095)), -1, "rand");
    end
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/factor_search_12.md
FACTOR_SEARCH_12 -- requirements
Module: factor_search_12

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port `clk`: input, 1 bit. System clock; all state updates on its rising edge.
REQ-003 Port `rst`: input, 1 bit. Asynchronous active-high reset.
REQ-004 Port `start`: input, 1 bit. Request a factor search of `a`; sampled only when `busy`=0.
REQ-005 Port `a`: input, 12 bits. Unsigned target value, bit 11 MSB; captured on an accepted `start`.
REQ-006 Port `busy`: output, 1 bit. Search in progress.
REQ-007 Port `done`: output, 1 bit. One-cycle pulse marking the end of a search.
REQ-008 Port `found`: output, 1 bit. Last search produced a non-trivial factor pair.
REQ-009 Port `f1`: output, 6 bits. Smaller factor, unsigned, bit 5 MSB.
REQ-010 Port `f2`: output, 6 bits. Larger factor, unsigned, bit 5 MSB.
REQ-011 Ports `f1` and `f2` SHALL be a pair accepted by the downstream product checker, i.e. f1*f2 == a with f1≠1 and f2≠1.

Function
REQ-012 The block SHALL implement states IDLE and SEARCH, plus registers `x`[5:0], `y`[5:0] and `tgt`[11:0].
REQ-013 In IDLE with `start`=1 at a rising edge, the block SHALL:
- set tgt←a, x←2, y←2;
- enter SEARCH;
- set busy←1;
- clear found, f1 and f2.
REQ-014 In SEARCH, each cycle SHALL evaluate p = x*y as a full 12-bit unsigned product, with no truncation (max 3969).
REQ-015 SEARCH decisions SHALL be evaluated in priority order:
1. p==tgt: set found←1, f1←x, f2←y, finish.
2. x*x>tgt, or (x==63 and (y==63 or p>tgt)): set found←0, finish.
3. p>tgt or y==63: set x←x+1, y←x+1.
4. Otherwise: set y←y+1.
REQ-016 On finish, the block SHALL go to IDLE, set busy←0, and assert done for exactly the next cycle.
REQ-017 Every pair with 2≤x≤y≤63 SHALL be visited in ascending (x, y) order until a finish condition occurs.
REQ-018 The reported pair SHALL be the one with the smallest f1; the block SHALL guarantee f1≤f2.
REQ-019 `found`, `f1` and `f2` SHALL hold their values from the end of a search until the next accepted start or reset.
REQ-020 `start` asserted while busy=1 SHALL be ignored, with no effect on tgt or the search.
REQ-021 `start` asserted in the cycle where done=1 SHALL be accepted (busy is already 0).
REQ-022 Latency from the start-sampling edge to done SHALL be (number of SEARCH evaluation cycles + 1) cycles.
REQ-023 Target values 0, 1, 2, 3 and primes SHALL produce found=0.
REQ-024 Values with no factor pair ≤63, e.g. 4095, SHALL produce found=0 after exhaustion.

Reset
REQ-025 While rst=1, the block SHALL asynchronously force:
- state IDLE;
- busy=0, done=0, found=0;
- f1=0, f2=0;
- x=0, y=0, tgt=0.
REQ-026 Reset asserted mid-search SHALL abort the search immediately with no done pulse.
REQ-027 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-028 Scenario: a=15, start at edge 0 -> 10 SEARCH cycles (2×2..2×8, 3×3..3×5); done high in cycle 11; found=1, f1=3, f2=5.
REQ-029 Scenario: a=13 -> 10 SEARCH cycles; done in cycle 11; found=0, f1=0, f2=0.
REQ-030 Scenario: a=4 -> match on the first evaluation; done in cycle 2; found=1, f1=2, f2=2.
REQ-031 Scenario: a=0 and a=1 -> one evaluation each; done in cycle 2; found=0.
REQ-032 Scenario: a=4095 -> 1953 SEARCH cycles; done in cycle 1954; found=0. A second start pulse at cycle 500 SHALL be ignored.
REQ-033 Scenario: a=3969, rst pulsed at cycle 100 -> busy, done, found, f1 and f2 all 0 immediately. A start of a=15 following reset SHALL then give the REQ-028 result.
